// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 3-stage core: run/halt/step control, stage valid tracking,
// jump squash and saturating retired/active-cycle counters.
module pipe_seq_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             id_jump,
    output logic             pc_en,
    output logic             pc_load,
    output logic             fetch_valid,
    output logic             squash_if,
    output logic             v_id,
    output logic             v_ex,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StHalted,
        StStep
    } state_e;

    state_e state_q, state_d;
    logic   jtake;
    logic   active;

    always_comb begin
        fetch_valid = (state_q == StRun) || (state_q == StStep);
        jtake       = id_jump & v_id;
        // A taken jump wins over sequential advance in every state, DRAIN included.
        pc_load     = jtake;
        pc_en       = fetch_valid & ~jtake;
        squash_if   = fetch_valid & jtake;
        active      = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (run_req) state_d = StRun;
            StRun:    if (halt_req) state_d = StDrain;
            StDrain:  if (!v_id && !v_ex) state_d = StHalted;
            StHalted: begin
                if (run_req && !halt_req) state_d = StRun;
                else if (step_req)        state_d = StStep;
            end
            StStep:   state_d = StDrain;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            running     <= 1'b0;
            halted      <= 1'b0;
            v_id        <= 1'b0;
            v_ex        <= 1'b0;
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            state_q <= state_d;
            running <= (state_d == StRun);
            halted  <= (state_d == StHalted);
            v_id    <= fetch_valid & ~squash_if;
            v_ex    <= v_id;
            if (v_ex && !(&retired_cnt)) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (active && !(&cycle_cnt)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule
